fetch_queue: RTL

Instruction fetch queue feeding the dispatch stage. It owns the architectural fetch PC and issues one outstanding word request at a time to the instruction cache. Each returned instruction is buffered with its PC+4 in a first-word-fall-through queue, which the dispatcher drains via its read enable. A jump or taken-branch redirect from dispatch flushes the queue, retargets the PC and discards any in-flight response.

---
 rtl/fetch_queue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with single outstanding icache request
//
// Owns the architectural fetch PC, issues one word request at a time to the
// instruction cache and buffers each returned word with its PC+4 in a
// first-word-fall-through queue drained by dispatch. A redirect flushes the
// queue, retargets the PC and drops any response still in flight.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_rd_en                 dispatcher pops the head entry
//   i_jmp_valid, i_jmp_addr redirect request and target
//   o_icache_req/addr       request valid (held until granted) and word address
//   i_icache_gnt            request accepted this cycle
//   i_icache_rsp_valid/data one response per grant
//   o_fetch_pc_plus_4       head entry PC+4 (0 when empty)
//   o_fetch_instruction     head entry instruction (0 when empty)
//   o_fetch_empty_flag      queue empty
//   o_fetch_full            queue holds DEPTH entries
//   o_occupancy             number of valid entries
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_rd_en,
    input  logic                     i_jmp_valid,
    input  logic [31:0]              i_jmp_addr,
    output logic                     o_icache_req,
    output logic [31:0]              o_icache_addr,
    input  logic                     i_icache_gnt,
    input  logic                     i_icache_rsp_valid,
    input  logic [31:0]              i_icache_rsp_data,
    output logic [31:0]              o_fetch_pc_plus_4,
    output logic [31:0]              o_fetch_instruction,
    output logic                     o_fetch_empty_flag,
    output logic                     o_fetch_full,
    output logic [$clog2(DEPTH):0]   o_occupancy
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic [31:0]   mem_pc4 [DEPTH];
    logic [31:0]   mem_ins [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          empty;
    logic          pop;
    logic          push;
    logic [AW:0]   count_after_pop;
    logic [AW:0]   count_next;
    logic [31:0]   rsp_pc4;

    // A redirect overrides both the pop and the response write, so neither
    // is allowed to touch pointers or count in that cycle.
    always_comb begin
        empty           = (count == '0);
        pop             = i_rd_en && !empty && !i_jmp_valid;
        push            = (state == WAIT) && i_icache_rsp_valid && !i_jmp_valid;
        rsp_pc4         = req_pc + 32'd4;
        count_after_pop = count - (AW + 1)'(pop);
        count_next      = count_after_pop + (AW + 1)'(push);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_jmp_valid) begin
            pc     <= i_jmp_addr;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // A request granted this cycle or still awaiting its response
            // must have that response swallowed before fetching restarts.
            case (state)
                IDLE:          state <= REQ;
                REQ:           state <= i_icache_gnt ? DISCARD : REQ;
                WAIT, DISCARD: state <= i_icache_rsp_valid ? REQ : DISCARD;
                default:       state <= IDLE;
            endcase
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem_pc4[wr_ptr] <= rsp_pc4;
                mem_ins[wr_ptr] <= i_icache_rsp_data;
                wr_ptr          <= wr_ptr + 1'b1;
                pc              <= rsp_pc4;
            end
            count <= count_next;
            // Only one request is ever outstanding, so starting one while
            // count_next < DEPTH guarantees its response has a free slot.
            case (state)
                IDLE: begin
                    if (count_next < DEPTH_CNT) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (i_icache_gnt) begin
                        req_pc <= pc;
                        state  <= WAIT;
                    end
                end
                WAIT, DISCARD: begin
                    if (i_icache_rsp_valid) begin
                        state <= (count_next < DEPTH_CNT) ? REQ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_icache_req        = (state == REQ);
        o_icache_addr       = pc;
        o_fetch_pc_plus_4   = empty ? 32'd0 : mem_pc4[rd_ptr];
        o_fetch_instruction = empty ? 32'd0 : mem_ins[rd_ptr];
        o_fetch_empty_flag  = empty;
        o_fetch_full        = (count == DEPTH_CNT);
        o_occupancy         = count;
    end

endmodule
